spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Transaction-level SPI initiator for the 64-bit frame format the SPI slave responds to: cmd[7:0], then address[23:0], then data[31:0], MSB first.
- Accepts one command per start pulse from a host-side handshake.
- Generates cs, sclk_s and mosi.
- For read commands, captures the 32-bit read word from miso.
- Replaces the free-running test master in system-level benches and in the host-side datapath.

Parameters:
CLK_DIV, 2, sclk_m cycles per sclk_s half-period (>=1)
CMD_WRITE, 8'h55, write opcode; data phase carries wdata
CMD_READ, 8'h56, read opcode; data phase samples miso

Ports:
sclk_m  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
cmd  in  8  opcode, captured on accepted start
address  in  24  address, captured on accepted start
wdata  in  32  write data, captured on accepted start
miso  in  1  serial data from slave
cs  out  1  chip select, active-low; idle 1
sclk_s  out  1  serial clock, idle 0 (mode 0)
mosi  out  1  serial data to slave
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end
rdata  out  32  last read word; held until next read completes
rd_valid  out  1  one-cycle pulse with done on read frames only
err_cmd  out  1  one-cycle pulse on rejected opcode

Behaviour:
- Reset values: cs=1, sclk_s=0, mosi=0, busy=0, done=0, rd_valid=0, err_cmd=0, rdata=0. FSM returns to IDLE and all counters clear.
- Reset mid-frame: on the reset edge, cs goes 1 and sclk_s goes 0. No done or rd_valid is issued and rdata clears. Reset has priority over all other inputs.
- Half-period tick: a divider counts 0..CLK_DIV-1 and ticks on the terminal count. It runs only outside IDLE.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 with cmd=CMD_WRITE or CMD_READ: latch a 64-bit shift register {cmd, address, D}, where D=wdata for writes and 32'h0 for reads. Latch is_read. Set busy=1, cs=0, mosi=frame MSB, then go to SETUP.
  - start=1 with any other cmd: pulse err_cmd for one cycle. cs stays 1 and busy stays 0; remain in IDLE.
- SETUP: lasts one half-period (CLK_DIV cycles), then enter SHIFT with bit_cnt=0.
- SHIFT (64 bits, 2*CLK_DIV cycles each):
  - First half-period: sclk_s=0, mosi stable.
  - On the tick, sclk_s rises. For bit_cnt 32..63 with is_read=1, sample miso into rdata_shift (MSB first).
  - Second half-period: sclk_s=1.
  - On the tick, sclk_s falls, the register shifts left, mosi takes the next bit, and bit_cnt increments.
  - After the falling edge of bit 63, go to HOLD.
- HOLD: cs stays 0 and sclk_s stays 0 for one half-period, then cs=1 and go to DONE.
- DONE (one cycle):
  - done=1 and busy=0.
  - If is_read: rdata<=rdata_shift and rd_valid=1.
  - Next state is IDLE. A start in the DONE cycle is ignored; it must be presented in IDLE.
- start outside IDLE is ignored with no error. Input fields are not re-sampled mid-frame.
- Latency: done pulses exactly 130*CLK_DIV+1 cycles after the edge that accepted start. cs is low for exactly 130*CLK_DIV cycles.
- Widths: bit_cnt is 7 bits. The divider counter is clog2(CLK_DIV) bits, minimum 1.

Decomposition:
- Package spi_pkg holds:
  - CMD_WRITE and CMD_READ defaults
  - CMD_W=8, ADDR_W=24, DATA_W=32, FRAME_BITS=64
  - the FSM state encoding, shared with the slave and the bench
- One sub-module, spi_clk_div: enable, CLK_DIV, tick output.

Test Plan:
1. Write: cmd=8'h55, address=24'h123456, wdata=32'hE2345678, CLK_DIV=2 -> mosi bits collected on sclk_s rising edges equal 64'h55123456E2345678. done at cycle 261 after start; rd_valid stays 0; slave data output equals 32'hE2345678.
2. Read: cmd=8'h56, address=24'h121212, miso model drives 32'hA5C30F81 in bits 32..63 -> mosi data phase all 0. rdata=32'hA5C30F81 together with rd_valid=1 and done=1.
3. Illegal opcode: cmd=8'h57 with start -> err_cmd high for exactly 1 cycle. cs stays 1, busy stays 0, and no sclk_s edges occur.
4. start pulsed at bit 10 of an active frame with different fields -> frame contents unchanged and exactly one done.
5. reset asserted during bit 20 -> cs=1, sclk_s=0 and rdata=0 on the next edge, with no done. A following write of 64'h5512345612121212 completes correctly.
6. CLK_DIV=1, two back-to-back writes with start held high -> second frame begins in the IDLE cycle after done. Both frames are correct, with cs high for at least 1 cycle between them.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator, slave and benches: frame geometry,
// default opcodes and the frame-sequencing state encoding.
package spi_pkg;

    localparam int CMD_W      = 8;
    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 32;
    localparam int FRAME_BITS = CMD_W + ADDR_W + DATA_W;

    localparam logic [CMD_W-1:0] CMD_WRITE_DEF = 8'h55;
    localparam logic [CMD_W-1:0] CMD_READ_DEF  = 8'h56;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    // Divider counter width: clog2 of the divide ratio, never below one bit.
    function automatic int div_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and ticks on
// the terminal count; held cleared while disabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic sclk_m,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sclk_m) begin
        if (reset || !enable) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/spi_master_ctrl.sv
// Transaction-level SPI initiator (mode 0): one 64-bit {cmd, address, data}
// frame per accepted start, MSB first, capturing miso in the data phase of reads.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int               CLK_DIV   = 2,
    parameter logic [CMD_W-1:0] CMD_WRITE = CMD_WRITE_DEF,
    parameter logic [CMD_W-1:0] CMD_READ  = CMD_READ_DEF
) (
    input  logic              sclk_m,
    input  logic              reset,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              miso,
    output logic              cs,
    output logic              sclk_s,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              err_cmd,
    output spi_state_t        fsm_state
);

    // Host handshake: start is a request honoured only while the FSM is IDLE
    // (busy low, not the DONE cycle); cmd/address/wdata are captured on that
    // edge and never re-sampled. busy stays high until the done pulse.

    spi_state_t        state, next_state;
    logic              tick;
    logic              div_en;
    logic              cmd_ok;
    logic              accept;
    logic              last_bit;
    logic [DATA_W-1:0] load_data;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [DATA_W-1:0]     rdata_shift;
    logic [6:0]            bit_cnt;
    logic                  is_read;

    assign cmd_ok    = (cmd == CMD_WRITE) || (cmd == CMD_READ);
    assign accept    = (state == ST_IDLE) && start && cmd_ok;
    assign load_data = (cmd == CMD_READ) ? DATA_W'(0) : wdata;
    assign last_bit  = (bit_cnt == 7'(FRAME_BITS - 1));
    assign mosi      = shift_reg[FRAME_BITS-1];
    assign fsm_state = state;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .sclk_m (sclk_m),
        .reset  (reset),
        .enable (div_en),
        .tick   (tick)
    );

    always_ff @(posedge sclk_m) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_SETUP;
            ST_SETUP: if (tick) next_state = ST_SHIFT;
            // Leave SHIFT only on the falling-edge tick of the last bit.
            ST_SHIFT: if (tick && sclk_s && last_bit) next_state = ST_HOLD;
            ST_HOLD:  if (tick) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cs       = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        rd_valid = 1'b0;
        div_en   = 1'b0;
        case (state)
            ST_SETUP, ST_SHIFT, ST_HOLD: begin
                cs     = 1'b0;
                busy   = 1'b1;
                div_en = 1'b1;
            end
            ST_DONE: begin
                done     = 1'b1;
                rd_valid = is_read;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk_m) begin
        if (reset) begin
            shift_reg   <= '0;
            rdata_shift <= '0;
            rdata       <= '0;
            bit_cnt     <= '0;
            is_read     <= 1'b0;
            sclk_s      <= 1'b0;
            err_cmd     <= 1'b0;
        end else begin
            err_cmd <= (state == ST_IDLE) && start && !cmd_ok;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg   <= {cmd, address, load_data};
                        is_read     <= (cmd == CMD_READ);
                        rdata_shift <= '0;
                        bit_cnt     <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (tick && !sclk_s) begin
                        sclk_s <= 1'b1;
                        // Bits 32..63 form the data phase; bit_cnt[5] marks it.
                        if (is_read && bit_cnt[5]) begin
                            rdata_shift <= {rdata_shift[DATA_W-2:0], miso};
                        end
                    end else if (tick) begin
                        sclk_s    <= 1'b0;
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + 7'd1;
                    end
                end
                ST_HOLD: begin
                    // Publish the read word as DONE is entered so it is valid with rd_valid.
                    if (tick && is_read) begin
                        rdata <= rdata_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a CLK_DIV=2 instance for most
// scenarios and a CLK_DIV=1 instance for back-to-back frames.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic sclk_m = 1'b0;
    logic reset  = 1'b1;
    always #5 sclk_m = ~sclk_m;

    logic              start = 1'b0;
    logic [7:0]        cmd = '0;
    logic [23:0]       address = '0;
    logic [31:0]       wdata = '0;
    logic              miso;
    logic              cs, sclk_s, mosi, busy, done, rd_valid, err_cmd;
    logic [31:0]       rdata;
    spi_state_t        fsm_state;

    logic              start_1 = 1'b0;
    logic [7:0]        cmd_1 = '0;
    logic [23:0]       address_1 = '0;
    logic [31:0]       wdata_1 = '0;
    logic              miso_1;
    logic              cs_1, sclk_s_1, mosi_1, busy_1, done_1, rd_valid_1, err_cmd_1;
    logic [31:0]       rdata_1;
    spi_state_t        fsm_state_1;

    spi_master_ctrl #(.CLK_DIV(2)) dut (
        .sclk_m(sclk_m), .reset(reset), .start(start), .cmd(cmd), .address(address),
        .wdata(wdata), .miso(miso), .cs(cs), .sclk_s(sclk_s), .mosi(mosi), .busy(busy),
        .done(done), .rdata(rdata), .rd_valid(rd_valid), .err_cmd(err_cmd),
        .fsm_state(fsm_state)
    );

    spi_master_ctrl #(.CLK_DIV(1)) dut_1 (
        .sclk_m(sclk_m), .reset(reset), .start(start_1), .cmd(cmd_1), .address(address_1),
        .wdata(wdata_1), .miso(miso_1), .cs(cs_1), .sclk_s(sclk_s_1), .mosi(mosi_1),
        .busy(busy_1), .done(done_1), .rdata(rdata_1), .rd_valid(rd_valid_1),
        .err_cmd(err_cmd_1), .fsm_state(fsm_state_1)
    );

    // Slave models: collect mosi on sclk_s rising edges, serve slave_rd in the data phase.
    logic [6:0]  rise_cnt   = '0;
    logic [63:0] mosi_cap   = '0;
    logic [31:0] slave_rd   = '0;
    logic [63:0] mosi_cap_1 = '0;

    always @(negedge cs) begin
        rise_cnt = '0;
        mosi_cap = '0;
    end
    always @(posedge sclk_s) begin
        mosi_cap = {mosi_cap[62:0], mosi};
        rise_cnt = rise_cnt + 7'd1;
    end
    always_comb begin
        int idx;
        idx  = 63 - int'(rise_cnt);
        miso = (idx >= 0 && idx < 32) ? slave_rd[idx[4:0]] : 1'b0;
    end

    always @(negedge cs_1) mosi_cap_1 = '0;
    always @(posedge sclk_s_1) mosi_cap_1 = {mosi_cap_1[62:0], mosi_1};
    assign miso_1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] last_rd = '0;

    task automatic drive_start(input logic [7:0] c, input logic [23:0] a, input logic [31:0] w);
        @(negedge sclk_m);
        cmd = c; address = a; wdata = w; start = 1'b1;
        @(posedge sclk_m);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int cs_low, output bit rdv_early);
        cyc = 0; cs_low = 0; rdv_early = 1'b0;
        while (cyc < budget) begin
            @(negedge sclk_m);
            cyc++;
            if (done) break;
            if (!cs) cs_low++;
            if (rd_valid) rdv_early = 1'b1;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic wait_rise(input int target);
        int t = 0;
        while (rise_cnt != 7'(target) && t < 400) begin
            @(negedge sclk_m);
            t++;
        end
        n_cmp++;
        if (rise_cnt != 7'(target)) begin
            n_bad++;
            $display("FAIL wait_rise: rise_cnt=%0d required %0d", rise_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge sclk_m);
        @(negedge sclk_m);
        n_cmp++;
        if ({cs, sclk_s, mosi, busy, done, rd_valid, err_cmd} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 1000000",
                     {cs, sclk_s, mosi, busy, done, rd_valid, err_cmd});
        end
        n_cmp++;
        if (rdata !== 32'h0 || fsm_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_rdata_state: rdata=%h state=%0d required 0/IDLE", rdata, fsm_state);
        end
        n_cmp++;
        if ({cs_1, sclk_s_1, mosi_1, busy_1, done_1, rd_valid_1, err_cmd_1} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_outputs_div1: got %b required 1000000",
                     {cs_1, sclk_s_1, mosi_1, busy_1, done_1, rd_valid_1, err_cmd_1});
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        int cyc, cs_low;
        bit rdv;
        logic [63:0] exp;
        exp_q.push_back(64'h55123456E2345678);
        drive_start(8'h55, 24'h123456, 32'hE2345678);
        n_cmp++;
        if ({cs, busy, mosi} !== 3'b010) begin
            n_bad++;
            $display("FAIL write_accept: cs/busy/mosi=%b required 010", {cs, busy, mosi});
        end
        wait_done(400, cyc, cs_low, rdv);
        exp = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 261) begin
            n_bad++;
            $display("FAIL write_latency: done at cycle %0d required 261", cyc);
        end
        n_cmp++;
        if (cs_low !== 260) begin
            n_bad++;
            $display("FAIL write_cs_low: %0d cycles required 260", cs_low);
        end
        n_cmp++;
        if (mosi_cap !== exp) begin
            n_bad++;
            $display("FAIL write_frame: got %h required %h", mosi_cap, exp);
        end
        n_cmp++;
        if (rd_valid !== 1'b0 || rdv || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL write_flags: rd_valid=%b early=%b busy=%b required 0/0/0", rd_valid, rdv, busy);
        end
        n_cmp++;
        if (mosi_cap[31:0] !== 32'hE2345678) begin
            n_bad++;
            $display("FAIL write_slave_data: got %h required e2345678", mosi_cap[31:0]);
        end
    endtask

    task automatic test_read();
        int cyc, cs_low;
        bit rdv;
        logic [63:0] exp;
        logic [31:0] exp_rd;
        slave_rd = 32'hA5C30F81;
        exp_q.push_back(64'h5612121200000000);
        exp_rd_q.push_back(32'hA5C30F81);
        drive_start(8'h56, 24'h121212, 32'hDEADBEEF);
        wait_done(400, cyc, cs_low, rdv);
        exp    = exp_q.pop_front();
        exp_rd = exp_rd_q.pop_front();
        last_rd = exp_rd;
        n_cmp++;
        if (rdata !== exp_rd || rd_valid !== 1'b1 || rdv) begin
            n_bad++;
            $display("FAIL read_data: rdata=%h rd_valid=%b early=%b required %h/1/0", rdata, rd_valid, rdv, exp_rd);
        end
        n_cmp++;
        if (mosi_cap !== exp) begin
            n_bad++;
            $display("FAIL read_frame: got %h required %h", mosi_cap, exp);
        end
        n_cmp++;
        if (cyc !== 261) begin
            n_bad++;
            $display("FAIL read_latency: done at cycle %0d required 261", cyc);
        end
        @(negedge sclk_m);
        n_cmp++;
        if (rdata !== exp_rd || rd_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL read_hold: rdata=%h rd_valid=%b done=%b required %h/0/0", rdata, rd_valid, done, exp_rd);
        end
        slave_rd = '0;
    endtask

    task automatic test_illegal();
        int err_hi = 0;
        bit bad = 1'b0;
        drive_start(8'h57, 24'h000001, 32'h1);
        repeat (20) begin
            @(negedge sclk_m);
            if (err_cmd === 1'b1) err_hi++;
            if (cs !== 1'b1 || busy !== 1'b0 || sclk_s !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (err_hi !== 1) begin
            n_bad++;
            $display("FAIL illegal_err_pulse: err_cmd high %0d cycles required 1", err_hi);
        end
        n_cmp++;
        if (bad || fsm_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL illegal_idle: activity=%b state=%0d required 0/IDLE", bad, fsm_state);
        end
    endtask

    task automatic test_start_midframe();
        int cyc, cs_low, n_done = 0;
        bit rdv, bad = 1'b0;
        logic [63:0] exp;
        exp_q.push_back(64'h55ABCDEF0F0F1234);
        drive_start(8'h55, 24'hABCDEF, 32'h0F0F1234);
        wait_rise(10);
        drive_start(8'h56, 24'h111111, 32'hFFFFFFFF);
        wait_done(400, cyc, cs_low, rdv);
        exp = exp_q.pop_front();
        n_cmp++;
        if (mosi_cap !== exp || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midstart_frame: got %h rd_valid=%b required %h/0", mosi_cap, rd_valid, exp);
        end
        repeat (40) begin
            @(negedge sclk_m);
            if (done === 1'b1) n_done++;
            if (busy !== 1'b0 || err_cmd !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (n_done !== 0 || bad || rdata !== last_rd) begin
            n_bad++;
            $display("FAIL midstart_single_done: extra_done=%0d activity=%b rdata=%h required 0/0/%h",
                     n_done, bad, rdata, last_rd);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc, cs_low, n_done = 0;
        bit rdv;
        logic [63:0] exp;
        drive_start(8'h55, 24'h777777, 32'h33333333);
        wait_rise(20);
        @(negedge sclk_m);
        reset = 1'b1;
        @(posedge sclk_m);
        #1;
        n_cmp++;
        if (cs !== 1'b1 || sclk_s !== 1'b0 || rdata !== 32'h0 || done !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL midreset: cs=%b sclk_s=%b rdata=%h done=%b state=%0d required 1/0/0/0/IDLE",
                     cs, sclk_s, rdata, done, fsm_state);
        end
        @(negedge sclk_m);
        reset = 1'b0;
        repeat (10) begin
            @(negedge sclk_m);
            if (done === 1'b1 || rd_valid === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_done: %0d done cycles required 0", n_done);
        end
        exp_q.push_back(64'h5512345612121212);
        drive_start(8'h55, 24'h123456, 32'h12121212);
        wait_done(400, cyc, cs_low, rdv);
        exp = exp_q.pop_front();
        n_cmp++;
        if (mosi_cap !== exp || cyc !== 261) begin
            n_bad++;
            $display("FAIL postreset_write: got %h at cycle %0d required %h at 261", mosi_cap, cyc, exp);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] exp;
        exp_q.push_back(64'h5500AAAA11111111);
        exp_q.push_back(64'h55BBBB0022223333);
        @(negedge sclk_m);
        cmd_1 = 8'h55; address_1 = 24'h00AAAA; wdata_1 = 32'h11111111; start_1 = 1'b1;
        @(posedge sclk_m);
        #1;
        cmd_1 = 8'h55; address_1 = 24'hBBBB00; wdata_1 = 32'h22223333;
        for (int f = 0; f < 2; f++) begin
            cyc = (f == 0) ? 0 : 1;
            while (cyc < 300 && done_1 !== 1'b1) begin
                @(negedge sclk_m);
                cyc++;
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if (done_1 !== 1'b1 || cyc !== 131 || mosi_cap_1 !== exp) begin
                n_bad++;
                $display("FAIL b2b_frame%0d: done=%b cycle=%0d got %h required 1/131/%h",
                         f, done_1, cyc, mosi_cap_1, exp);
            end
            if (f == 0) begin
                @(negedge sclk_m);
                n_cmp++;
                if (cs_1 !== 1'b1 || fsm_state_1 !== ST_IDLE) begin
                    n_bad++;
                    $display("FAIL b2b_gap: cs=%b state=%0d required 1/IDLE", cs_1, fsm_state_1);
                end
                @(negedge sclk_m);
                n_cmp++;
                if (cs_1 !== 1'b0 || busy_1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_restart: cs=%b busy=%b required 0/1", cs_1, busy_1);
                end
                start_1 = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_start_midframe();
        test_reset_midframe();
        test_back_to_back();
        repeat (5) @(negedge sclk_m);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
